// File: rtl/slot_dispatcher.sv
// slot_dispatcher: walks the slot bank once per start pulse. Every PENDING slot
// is marked RUNNING, issued downstream as a command, and marked DONE (or put
// back to IDLE on error) once the engine reports completion.
module slot_dispatcher #(
  parameter int NUM_SLOTS     = 2,
  parameter int IDX_WIDTH     = 1,
  parameter int ADDR_WIDTH    = 32,
  parameter int SIZE_WIDTH    = 26,
  parameter int STATUS_WIDTH  = 2,
  parameter int PROFILE_WIDTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [NUM_SLOTS*ADDR_WIDTH-1:0]    slot_addr_flat,
  input  logic [NUM_SLOTS*SIZE_WIDTH-1:0]    slot_size_flat,
  input  logic [NUM_SLOTS*STATUS_WIDTH-1:0]  slot_status_flat,
  input  logic [NUM_SLOTS*PROFILE_WIDTH-1:0] slot_profile_flat,
  output logic                               cmd_valid,
  input  logic                               cmd_ready,
  output logic [ADDR_WIDTH-1:0]              cmd_addr,
  output logic [SIZE_WIDTH-1:0]              cmd_size,
  output logic [PROFILE_WIDTH-1:0]           cmd_profile,
  output logic [IDX_WIDTH-1:0]               cmd_idx,
  input  logic                               done_valid,
  input  logic                               done_err,
  output logic [IDX_WIDTH-1:0]               wb_idx,
  output logic [STATUS_WIDTH-1:0]            wb_status,
  output logic                               wb_set_status,
  output logic                               busy,
  output logic                               all_done,
  output logic                               err_sticky
);

  localparam logic [STATUS_WIDTH-1:0] ST_IDLE    = STATUS_WIDTH'(0);
  localparam logic [STATUS_WIDTH-1:0] ST_PENDING = STATUS_WIDTH'(1);
  localparam logic [STATUS_WIDTH-1:0] ST_RUNNING = STATUS_WIDTH'(2);
  localparam logic [STATUS_WIDTH-1:0] ST_DONE    = STATUS_WIDTH'(3);
  localparam logic [IDX_WIDTH-1:0]    LAST_IDX   = IDX_WIDTH'(NUM_SLOTS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_WB_RUN, S_ISSUE, S_WAIT, S_WB_DONE, S_NEXT, S_FINISH
  } state_t;

  state_t                     state_q;
  logic [IDX_WIDTH-1:0]       ptr_q;
  logic                       cmd_valid_q;
  logic [ADDR_WIDTH-1:0]      cmd_addr_q;
  logic [SIZE_WIDTH-1:0]      cmd_size_q;
  logic [PROFILE_WIDTH-1:0]   cmd_profile_q;
  logic [IDX_WIDTH-1:0]       cmd_idx_q;
  logic [IDX_WIDTH-1:0]       wb_idx_q;
  logic [STATUS_WIDTH-1:0]    wb_status_q;
  logic                       wb_set_q;
  logic                       busy_q;
  logic                       all_done_q;
  logic                       err_sticky_q;
  logic                       done_err_q;

  logic [ADDR_WIDTH-1:0]      addr_a    [NUM_SLOTS];
  logic [SIZE_WIDTH-1:0]      size_a    [NUM_SLOTS];
  logic [STATUS_WIDTH-1:0]    status_a  [NUM_SLOTS];
  logic [PROFILE_WIDTH-1:0]   profile_a [NUM_SLOTS];

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_unpack
    assign addr_a[g]    = slot_addr_flat[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign size_a[g]    = slot_size_flat[g*SIZE_WIDTH +: SIZE_WIDTH];
    assign status_a[g]  = slot_status_flat[g*STATUS_WIDTH +: STATUS_WIDTH];
    assign profile_a[g] = slot_profile_flat[g*PROFILE_WIDTH +: PROFILE_WIDTH];
  end

  // Scan FSM; every output is a register updated alongside the state change
  // so nothing downstream sees a combinational path from cmd_ready/done_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_size_q    <= '0;
      cmd_profile_q <= '0;
      cmd_idx_q     <= '0;
      wb_idx_q      <= '0;
      wb_status_q   <= '0;
      wb_set_q      <= 1'b0;
      busy_q        <= 1'b0;
      all_done_q    <= 1'b0;
      err_sticky_q  <= 1'b0;
      done_err_q    <= 1'b0;
    end else begin
      wb_set_q   <= 1'b0;
      all_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ptr_q        <= '0;
            err_sticky_q <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= S_SCAN;
          end
        end
        S_SCAN: begin
          // Slot contents are captured here and only here.
          if (status_a[ptr_q] == ST_PENDING) begin
            cmd_addr_q    <= addr_a[ptr_q];
            cmd_size_q    <= size_a[ptr_q];
            cmd_profile_q <= profile_a[ptr_q];
            cmd_idx_q     <= ptr_q;
            wb_set_q      <= 1'b1;
            wb_idx_q      <= ptr_q;
            wb_status_q   <= ST_RUNNING;
            state_q       <= S_WB_RUN;
          end else begin
            state_q <= S_NEXT;
          end
        end
        S_WB_RUN: begin
          cmd_valid_q <= 1'b1;
          state_q     <= S_ISSUE;
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (done_valid) begin
            done_err_q  <= done_err;
            wb_set_q    <= 1'b1;
            wb_idx_q    <= ptr_q;
            wb_status_q <= done_err ? ST_IDLE : ST_DONE;
            state_q     <= S_WB_DONE;
          end
        end
        S_WB_DONE: begin
          if (done_err_q) err_sticky_q <= 1'b1;
          state_q <= S_NEXT;
        end
        S_NEXT: begin
          if (ptr_q == LAST_IDX) begin
            all_done_q <= 1'b1;
            state_q    <= S_FINISH;
          end else begin
            ptr_q   <= ptr_q + 1'b1;
            state_q <= S_SCAN;
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_valid     = cmd_valid_q;
  assign cmd_addr      = cmd_addr_q;
  assign cmd_size      = cmd_size_q;
  assign cmd_profile   = cmd_profile_q;
  assign cmd_idx       = cmd_idx_q;
  assign wb_idx        = wb_idx_q;
  assign wb_status     = wb_status_q;
  assign wb_set_status = wb_set_q;
  assign busy          = busy_q;
  assign all_done      = all_done_q;
  assign err_sticky    = err_sticky_q;

endmodule

// File: tb/tb_slot_dispatcher.sv
// Randomized bench for slot_dispatcher: a responder emulates the downstream
// engine with random ready/done delays and errors; a per-scan reference model
// derives the expected commands, write-backs, latency and error flag.
module tb_slot_dispatcher;

  localparam int NS = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [NS*32-1:0]   slot_addr_flat;
  logic [NS*26-1:0]   slot_size_flat;
  logic [NS*2-1:0]    slot_status_flat;
  logic [NS*4-1:0]    slot_profile_flat;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [31:0]        cmd_addr;
  logic [25:0]        cmd_size;
  logic [3:0]         cmd_profile;
  logic [1:0]         cmd_idx;
  logic               done_valid;
  logic               done_err;
  logic [1:0]         wb_idx;
  logic [1:0]         wb_status;
  logic               wb_set_status;
  logic               busy;
  logic               all_done;
  logic               err_sticky;

  slot_dispatcher #(
    .NUM_SLOTS(NS), .IDX_WIDTH(2), .ADDR_WIDTH(32), .SIZE_WIDTH(26),
    .STATUS_WIDTH(2), .PROFILE_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .slot_addr_flat(slot_addr_flat), .slot_size_flat(slot_size_flat),
    .slot_status_flat(slot_status_flat), .slot_profile_flat(slot_profile_flat),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmd_profile(cmd_profile), .cmd_idx(cmd_idx),
    .done_valid(done_valid), .done_err(done_err),
    .wb_idx(wb_idx), .wb_status(wb_status), .wb_set_status(wb_set_status),
    .busy(busy), .all_done(all_done), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // Slot bank contents, written only by the main process
  logic [31:0] s_addr [NS];
  logic [25:0] s_size [NS];
  logic [1:0]  s_st   [NS];
  logic [3:0]  s_prof [NS];

  always_comb begin
    slot_addr_flat    = '0;
    slot_size_flat    = '0;
    slot_status_flat  = '0;
    slot_profile_flat = '0;
    for (int i = 0; i < NS; i++) begin
      slot_addr_flat[i*32 +: 32]   = s_addr[i];
      slot_size_flat[i*26 +: 26]   = s_size[i];
      slot_status_flat[i*2 +: 2]   = s_st[i];
      slot_profile_flat[i*4 +: 4]  = s_prof[i];
    end
  end

  // Responder configuration, written by main, read by responder
  int rd_lo = 0, rd_hi = 0, dd_lo = 0, dd_hi = 0, err_mode = 0;
  int clr_req = 0;

  // Responder-owned observation state
  int          cyc = 0, clr_seen = 0, done_cnt = 0, done_at = 0, hold_bad = 0;
  logic [63:0] obs_cmd [$];
  logic [63:0] obs_wb  [$];
  bit          rec_err [$];
  int          rec_rd  [$];
  int          rec_dd  [$];
  bit          mon_pending = 0, mon_in_issue = 0, mon_err = 0;
  int          mon_rwait = 0, mon_dwait = 0, mon_rd = 0;
  logic [63:0] mon_held = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Downstream engine emulation, acting 1 time unit after each rising edge
  initial begin
    logic [63:0] payload;
    bit          e;
    int          dd;
    cmd_ready  = 1'b0;
    done_valid = 1'b0;
    done_err   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (clr_req != clr_seen) begin
        clr_seen = clr_req;
        obs_cmd.delete(); obs_wb.delete();
        rec_err.delete(); rec_rd.delete(); rec_dd.delete();
        done_cnt = 0; hold_bad = 0;
      end
      if (reset) begin
        mon_pending = 0; mon_in_issue = 0;
        cmd_ready = 1'b0; done_valid = 1'b0; done_err = 1'b0;
      end else begin
        if (wb_set_status) obs_wb.push_back(64'({wb_idx, wb_status}));
        if (all_done) begin
          if (done_cnt == 0) done_at = cyc;
          done_cnt++;
        end
        done_valid = 1'b0;
        done_err   = 1'b0;
        if (mon_pending) begin
          if (mon_dwait == 0) begin
            done_valid = 1'b1; done_err = mon_err; mon_pending = 0;
          end else mon_dwait--;
        end else if ($urandom_range(0, 7) == 0) begin
          // stray completion outside WAIT must be ignored
          done_valid = 1'b1; done_err = 1'b1;
        end
        payload = {cmd_idx, cmd_profile, cmd_size, cmd_addr};
        if (cmd_valid) begin
          if (!mon_in_issue) begin
            mon_in_issue = 1;
            mon_rwait    = $urandom_range(rd_lo, rd_hi);
            mon_rd       = mon_rwait;
            mon_held     = payload;
          end else if (payload !== mon_held) hold_bad++;
          if (mon_rwait > 0) begin
            cmd_ready = 1'b0;
            mon_rwait--;
          end else begin
            cmd_ready = 1'b1;
            obs_cmd.push_back(payload);
            case (err_mode)
              1:       e = ($urandom_range(0, 3) == 0);
              2:       e = (rec_err.size() == 0);
              default: e = 0;
            endcase
            dd = $urandom_range(dd_lo, dd_hi);
            rec_err.push_back(e); rec_rd.push_back(mon_rd); rec_dd.push_back(dd);
            mon_pending = 1; mon_dwait = dd; mon_err = e;
            mon_in_issue = 0;
          end
        end else begin
          cmd_ready = 1'(($urandom_range(0, 1)));
        end
      end
    end
  end

  task automatic set_slot(input int i, input logic [1:0] st, input logic [31:0] a,
                          input logic [25:0] s, input logic [3:0] p);
    s_st[i] = st; s_addr[i] = a; s_size[i] = s; s_prof[i] = p;
  endtask

  task automatic randomize_slots();
    for (int i = 0; i < NS; i++)
      set_slot(i, 2'($urandom_range(0, 3)), $urandom, 26'($urandom), 4'($urandom));
  endtask

  // One full scan checked against the model built from a snapshot at start
  task automatic run_scan(input bit mutate, input bit dup);
    logic [31:0] e_addr [NS];
    logic [25:0] e_size [NS];
    logic [1:0]  e_st   [NS];
    logic [3:0]  e_prof [NS];
    logic [63:0] exp_cmd [$];
    logic [63:0] exp_wb  [$];
    int  t0, n, lat, k, rd, dd;
    bit  err, any_err;
    for (int i = 0; i < NS; i++) begin
      e_addr[i] = s_addr[i]; e_size[i] = s_size[i]; e_st[i] = s_st[i]; e_prof[i] = s_prof[i];
    end
    @(negedge clk);
    start = 1'b1; clr_req++; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check_eq("err_clear_on_start", 64'(err_sticky), 64'(0));
    check_eq("busy_in_scan", 64'(busy), 64'(1));
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      if (mutate && cmd_valid) begin
        s_addr[cmd_idx] = $urandom; s_size[cmd_idx] = 26'($urandom); s_prof[cmd_idx] = 4'($urandom);
      end
      start = dup && (n == 2);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (done_cnt == 0) check_eq("all_done_timeout", 64'(0), 64'(1));
    lat = 1; k = 0; any_err = 0;
    for (int i = 0; i < NS; i++) begin
      if (e_st[i] == 2'd1) begin
        err = (k < rec_err.size()) ? rec_err[k] : 1'b0;
        rd  = (k < rec_rd.size())  ? rec_rd[k]  : 0;
        dd  = (k < rec_dd.size())  ? rec_dd[k]  : 0;
        exp_cmd.push_back({2'(i), e_prof[i], e_size[i], e_addr[i]});
        exp_wb.push_back(64'({2'(i), 2'd2}));
        exp_wb.push_back(64'({2'(i), err ? 2'd0 : 2'd3}));
        lat += 6 + rd + dd;
        any_err |= err;
        k++;
      end else lat += 2;
    end
    check_eq("cmd_count", 64'(obs_cmd.size()), 64'(exp_cmd.size()));
    for (int j = 0; j < obs_cmd.size() && j < exp_cmd.size(); j++)
      check_eq("cmd_payload", obs_cmd[j], exp_cmd[j]);
    check_eq("wb_count", 64'(obs_wb.size()), 64'(exp_wb.size()));
    for (int j = 0; j < obs_wb.size() && j < exp_wb.size(); j++)
      check_eq("wb_event", obs_wb[j], exp_wb[j]);
    check_eq("cmd_hold_stable", 64'(hold_bad), 64'(0));
    check_eq("all_done_latency", 64'(done_at - t0), 64'(lat));
    check_eq("err_sticky", 64'(err_sticky), 64'(any_err));
    @(negedge clk);
    check_eq("busy_after_finish", 64'(busy), 64'(0));
    check_eq("cmd_valid_after_finish", 64'(cmd_valid), 64'(0));
    repeat (3) @(negedge clk);
    check_eq("single_all_done", 64'(done_cnt), 64'(1));
    check_eq("busy_stays_low", 64'(busy), 64'(0));
  endtask

  task automatic idle_window(input string tag);
    clr_req++;
    repeat (20) @(negedge clk);
    check_eq({tag, "_no_wb"}, 64'(obs_wb.size()), 64'(0));
    check_eq({tag, "_no_cmd"}, 64'(obs_cmd.size()), 64'(0));
    check_eq({tag, "_no_all_done"}, 64'(done_cnt), 64'(0));
    check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    check_eq({tag, "_err_sticky"}, 64'(err_sticky), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctrl"}, 64'({cmd_valid, busy, wb_set_status, all_done, err_sticky}), 64'(0));
    check_eq({tag, "_cmd"}, {cmd_idx, cmd_profile, cmd_size, cmd_addr}, 64'(0));
    check_eq({tag, "_wb"}, 64'({wb_idx, wb_status}), 64'(0));
  endtask

  // Abort a scan with reset while in ISSUE (phase 0) or WAIT (phase 1)
  task automatic reset_abort(input int phase);
    int n;
    for (int i = 0; i < NS; i++) set_slot(i, 2'd1, $urandom, 26'($urandom), 4'($urandom));
    rd_lo = (phase == 0) ? 30 : 0; rd_hi = rd_lo;
    dd_lo = (phase == 0) ? 0 : 30; dd_hi = dd_lo;
    err_mode = 0;
    @(negedge clk);
    start = 1'b1; clr_req++;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!((phase == 0) ? cmd_valid : (rec_err.size() > 0)) && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) check_eq("abort_reach_timeout", 64'(0), 64'(1));
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_before_abort", 64'(busy), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort_reset");
    reset = 1'b0;
    idle_window("after_abort");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < NS; i++) set_slot(i, 2'd0, 32'd0, 26'd0, 4'd0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    reset = 1'b0;
    idle_window("idle20");

    // Two pending slots, ready high, done one cycle after handshake
    set_slot(0, 2'd1, 32'h1000, 26'h40, 4'd3);
    set_slot(1, 2'd1, 32'h2000, 26'h80, 4'd5);
    set_slot(2, 2'd0, 32'h3000, 26'h10, 4'd1);
    set_slot(3, 2'd0, 32'h4000, 26'h20, 4'd2);
    rd_lo = 0; rd_hi = 0; dd_lo = 0; dd_hi = 0; err_mode = 0;
    run_scan(1'b0, 1'b0);

    // Slot 0 idle: skipped without command or write-back
    s_st[0] = 2'd0;
    run_scan(1'b0, 1'b0);

    // Backpressure with slot contents changing under the in-flight command
    s_st[0] = 2'd1; s_st[1] = 2'd0;
    rd_lo = 5; rd_hi = 5;
    run_scan(1'b1, 1'b0);

    // Error on slot 0, slot 1 still processed
    set_slot(0, 2'd1, 32'h1000, 26'h40, 4'd3);
    set_slot(1, 2'd1, 32'h2000, 26'h80, 4'd5);
    rd_lo = 0; rd_hi = 0; err_mode = 2;
    run_scan(1'b0, 1'b0);

    // Random traffic; the first scan also proves the start clears err_sticky
    for (int t = 0; t < 30; t++) begin
      randomize_slots();
      if (t == 0) s_st[0] = 2'd1;
      rd_lo = 0; rd_hi = $urandom_range(0, 3);
      dd_lo = 0; dd_hi = $urandom_range(0, 3);
      err_mode = (t == 0) ? 0 : 1;
      run_scan(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
    end

    reset_abort(0);
    reset_abort(1);

    // Recovery after abort
    randomize_slots();
    s_st[NS-1] = 2'd1;
    rd_lo = 0; rd_hi = 2; dd_lo = 0; dd_hi = 2; err_mode = 1;
    run_scan(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slot_dispatcher.md
Name: slot_dispatcher

Overview:
Reader/consumer side of the slot register bank. On a start pulse it walks all slots in index order, picks up every slot whose status is PENDING, issues that slot's address/size/profile as a command to the downstream DMA/reconfig engine over a valid/ready handshake, and waits for completion. It writes each slot's status back through the slot bank's own write bus (index, status data, set strobe), so one dispatcher drives all slots.

Parameters:
NUM_SLOTS, 2, number of slots scanned (>=1)
IDX_WIDTH, 1, slot index width, ceil(log2(NUM_SLOTS)), min 1
ADDR_WIDTH, 32, slot address width
SIZE_WIDTH, 26, slot size width
STATUS_WIDTH, 2, slot status width (encoding: 0 IDLE, 1 PENDING, 2 RUNNING, 3 DONE)
PROFILE_WIDTH, 4, slot profile width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse that begins a scan; ignored unless in IDLE
slot_addr_flat  in  NUM_SLOTS*ADDR_WIDTH  slot i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
slot_size_flat  in  NUM_SLOTS*SIZE_WIDTH  slot sizes, same packing
slot_status_flat  in  NUM_SLOTS*STATUS_WIDTH  slot statuses, same packing
slot_profile_flat  in  NUM_SLOTS*PROFILE_WIDTH  slot profiles, same packing
cmd_valid  out  1  command valid
cmd_ready  in  1  downstream accepts command
cmd_addr  out  ADDR_WIDTH  latched slot address
cmd_size  out  SIZE_WIDTH  latched slot size
cmd_profile  out  PROFILE_WIDTH  latched slot profile
cmd_idx  out  IDX_WIDTH  slot index of the command
done_valid  in  1  one-cycle completion pulse from downstream
done_err  in  1  completion error flag, qualified by done_valid
wb_idx  out  IDX_WIDTH  status write-back slot index
wb_status  out  STATUS_WIDTH  status write-back data
wb_set_status  out  1  status write-back strobe, one cycle
busy  out  1  high whenever state != IDLE
all_done  out  1  one-cycle pulse at end of scan
err_sticky  out  1  set on any done_err, cleared by reset or by an accepted start

Behaviour:
- Reset: state IDLE, ptr 0; cmd_valid, wb_set_status, busy, all_done, err_sticky = 0; cmd_addr/size/profile/idx, wb_idx, wb_status = 0. Reset mid-operation aborts immediately. No write-back is issued, and cmd_valid falls in the cycle after the reset edge.
- States: IDLE, SCAN, WB_RUN, ISSUE, WAIT, WB_DONE, NEXT, FINISH.
- IDLE: start=1 -> ptr<=0, err_sticky<=0, go to SCAN.
- SCAN (1 cycle per slot): if status[ptr]==PENDING, latch addr/size/profile[ptr] into the cmd_* registers, set cmd_idx<=ptr, and go to WB_RUN. Otherwise go to NEXT.
- WB_RUN (1 cycle): wb_set_status=1, wb_idx=ptr, wb_status=2 (RUNNING); then go to ISSUE.
- ISSUE: cmd_valid=1 and payload held stable until the edge where cmd_ready=1; then go to WAIT. cmd_ready may already be high on entry, giving a 1-cycle ISSUE.
- WAIT: on done_valid=1, record done_err and go to WB_DONE. done_valid is ignored in every other state.
- WB_DONE (1 cycle): wb_set_status=1, wb_idx=ptr. wb_status=3 (DONE) on success, 0 (IDLE) on error; on error err_sticky<=1. Then go to NEXT.
- NEXT (1 cycle): if ptr==NUM_SLOTS-1 go to FINISH, else ptr<=ptr+1 and go to SCAN. No wrap-around: each slot is visited exactly once per start.
- FINISH (1 cycle): all_done=1; then go to IDLE.
- Outputs are registered or decoded from state only. No combinational path from cmd_ready or done_valid to any output.
- Slot contents are sampled only in SCAN. Changes to a slot after its SCAN cycle do not affect the command in flight.
- start while busy: ignored, no queuing. start in the same cycle as reset: reset wins.
- Latency, idle slot: 2 cycles (SCAN+NEXT). Pending slot, with ready already high and done one cycle after handshake: SCAN, WB_RUN, ISSUE, WAIT, WB_DONE, NEXT = 6 cycles.
- Status write-back uses the slot bank's index-qualified set_status path. The dispatcher never writes addr, size or profile.

Test Plan:
- Reset then idle: no start for 20 cycles -> busy=0, cmd_valid=0, wb_set_status=0, all_done never pulses.
- NUM_SLOTS=2, statuses {1,1}, addrs {0x1000,0x2000}, sizes {0x40,0x80}, profiles {3,5}, cmd_ready=1, done 1 cycle after handshake -> two commands in order (idx 0 then 1) with matching payloads; wb sequence (0,2),(0,3),(1,2),(1,3); all_done pulses once; busy low the following cycle.
- Statuses {0,1}: slot 0 skipped with no write-back and no command; only slot 1 issued; all_done 2+6+1 cycles after start acceptance (slot 0 SCAN/NEXT, slot 1 six-cycle sequence, FINISH).
- Backpressure: cmd_ready low for 5 cycles in ISSUE, slot address changed during those cycles -> cmd_valid held high, cmd_addr stays at the value latched in SCAN, single handshake.
- Error: done_err=1 on slot 0 -> wb_status=0 for slot 0, err_sticky=1, slot 1 still processed. A new start clears err_sticky.
- Reset during WAIT, plus done_valid pulsed while in IDLE and start pulsed while busy -> after reset all outputs 0 with no write-back; stray done_valid is ignored; start while busy causes no second scan.
